// File: rtl/iter_alu_if.sv
// Operand/result handshake bundle between the datapath and iter_alu.
interface iter_alu_if #(parameter int unsigned WIDTH = 32);
    logic             in_valid;
    logic             ready;
    logic [3:0]       S;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             out_valid;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result2;
    logic             Equal;
    logic             overflow;
    logic             UOF;
    logic             div0;

    modport master (output in_valid, S, X, Y,
                    input  ready, out_valid, Result, Result2, Equal, overflow, UOF, div0);
    modport slave  (input  in_valid, S, X, Y,
                    output ready, out_valid, Result, Result2, Equal, overflow, UOF, div0);
endinterface

// File: rtl/iter_alu.sv
// Sequential ALU: single-cycle logic/shift/add/compare, 1 bit/cycle multiply and restoring divide.
// Define ALU_SIGNED_MULDIV_EN to enable signed MULS/DIVS (S=13/14); otherwise those codes are reserved.
module iter_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    iter_alu_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_MULU = 4'd3;
    localparam logic [3:0] OP_DIVU = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;
    localparam logic [3:0] OP_MULS = 4'd13;
    localparam logic [3:0] OP_DIVS = 4'd14;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t             state;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   hi, lo, opnd;
    logic               is_div, dz, eq;
`ifdef ALU_SIGNED_MULDIV_EN
    logic               neg_lo, neg_hi;
`endif

    logic               md_op, div_op, x_neg, y_neg;
    logic [WIDTH-1:0]   x_mag, y_mag, sc_res;
    logic               sc_ovf, sc_uof;
    logic [WIDTH:0]     add_sum, sub_dif, mul_sum, div_sh, div_dif;
    logic [WIDTH-1:0]   st_hi, st_lo, fin_lo, fin_hi;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     sh;

    // Op decode and operand magnitudes for the iterative unit
    always_comb begin
        md_op  = (bus.S == OP_MULU) || (bus.S == OP_DIVU);
        div_op = (bus.S == OP_DIVU);
        x_neg  = 1'b0;
        y_neg  = 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
        if (bus.S == OP_MULS || bus.S == OP_DIVS) begin
            md_op = 1'b1;
            x_neg = bus.X[WIDTH-1];
            y_neg = bus.Y[WIDTH-1];
        end
        if (bus.S == OP_DIVS) div_op = 1'b1;
`endif
        x_mag = x_neg ? -bus.X : bus.X;
        y_mag = y_neg ? -bus.Y : bus.Y;
    end

    // Single-cycle datapath
    always_comb begin
        sh      = bus.Y[SHW-1:0];
        add_sum = {1'b0, bus.X} + {1'b0, bus.Y};
        sub_dif = {1'b0, bus.X} - {1'b0, bus.Y};
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_uof  = 1'b0;
        case (bus.S)
            OP_SLL:  sc_res = bus.X << sh;
            OP_SRA:  sc_res = $signed(bus.X) >>> sh;
            OP_SRL:  sc_res = bus.X >> sh;
            OP_ADD: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_uof = add_sum[WIDTH];
                sc_ovf = (bus.X[WIDTH-1] == bus.Y[WIDTH-1]) && (add_sum[WIDTH-1] != bus.X[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_dif[WIDTH-1:0];
                sc_uof = sub_dif[WIDTH];
                sc_ovf = (bus.X[WIDTH-1] != bus.Y[WIDTH-1]) && (sub_dif[WIDTH-1] != bus.X[WIDTH-1]);
            end
            OP_AND:  sc_res = bus.X & bus.Y;
            OP_OR:   sc_res = bus.X | bus.Y;
            OP_XOR:  sc_res = bus.X ^ bus.Y;
            OP_NOR:  sc_res = ~(bus.X | bus.Y);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.X) < $signed(bus.Y))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.X < bus.Y)};
            default: sc_res = '0;
        endcase
    end

    // One iteration: shift-add multiply or restoring divide step on {hi,lo}
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_sh  = {hi, lo[WIDTH-1]};
        div_dif = div_sh - {1'b0, opnd};
        if (is_div) begin
            st_hi = div_dif[WIDTH] ? div_sh[WIDTH-1:0] : div_dif[WIDTH-1:0];
            st_lo = {lo[WIDTH-2:0], ~div_dif[WIDTH]};
        end else begin
            st_hi = mul_sum[WIDTH:1];
            st_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Final result from the last iteration; with Y==0 the remainder path already holds |X|
    always_comb begin
        prod   = {st_hi, st_lo};
        fin_lo = st_lo;
        fin_hi = st_hi;
        if (is_div) begin
`ifdef ALU_SIGNED_MULDIV_EN
            if (neg_lo) fin_lo = -st_lo;
            if (neg_hi) fin_hi = -st_hi;
`endif
            if (dz) fin_lo = '1;
        end else begin
`ifdef ALU_SIGNED_MULDIV_EN
            if (neg_lo) prod = -prod;
`endif
            fin_lo = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            hi            <= '0;
            lo            <= '0;
            opnd          <= '0;
            is_div        <= 1'b0;
            dz            <= 1'b0;
            eq            <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_lo        <= 1'b0;
            neg_hi        <= 1'b0;
`endif
            bus.ready     <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.Result    <= '0;
            bus.Result2   <= '0;
            bus.Equal     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.UOF       <= 1'b0;
            bus.div0      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (md_op) begin
                            state     <= BUSY;
                            bus.ready <= 1'b0;
                            cnt       <= '0;
                            hi        <= '0;
                            lo        <= div_op ? x_mag : y_mag;
                            opnd      <= div_op ? y_mag : x_mag;
                            is_div    <= div_op;
                            dz        <= div_op && (bus.Y == '0);
                            eq        <= (bus.X == bus.Y);
`ifdef ALU_SIGNED_MULDIV_EN
                            neg_lo    <= x_neg ^ y_neg;
                            neg_hi    <= x_neg;
`endif
                        end else begin
                            bus.out_valid <= 1'b1;
                            bus.Result    <= sc_res;
                            bus.Result2   <= '0;
                            bus.Equal     <= (bus.X == bus.Y);
                            bus.overflow  <= sc_ovf;
                            bus.UOF       <= sc_uof;
                            bus.div0      <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    hi  <= st_hi;
                    lo  <= st_lo;
                    cnt <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state         <= FIX;
                        bus.out_valid <= 1'b1;
                        bus.Result    <= fin_lo;
                        bus.Result2   <= fin_hi;
                        bus.Equal     <= eq;
                        bus.overflow  <= 1'b0;
                        bus.UOF       <= 1'b0;
                        bus.div0      <= dz;
                    end
                end
                FIX: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: arithmetic reference model checked every cycle, plus literal spot checks.
module tb_iter_alu;
    localparam int unsigned W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    iter_alu_if #(.WIDTH(W)) bus ();
    iter_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] res2;
        logic         eq, ovf, uof, dz;
        int           e;
    } rec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_long(input logic [3:0] s);
`ifdef ALU_SIGNED_MULDIV_EN
        return s == 4'd3 || s == 4'd4 || s == 4'd13 || s == 4'd14;
`else
        return s == 4'd3 || s == 4'd4;
`endif
    endfunction

    // Reference results from plain wide arithmetic
    function automatic rec_t model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        rec_t r;
        longint sx, sy, t;
        logic [63:0] p;
        logic [4:0] sh;
        r = '{default: '0};
        r.eq = (x == y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = y[4:0];
        case (s)
            4'd0:  r.res = x << sh;
            4'd1:  r.res = W'(sx >>> sh);
            4'd2:  r.res = x >> sh;
            4'd3:  begin p = 64'(x) * 64'(y); r.res = p[31:0]; r.res2 = p[63:32]; end
            4'd4:  if (y == 0) begin r.res = '1; r.res2 = x; r.dz = 1'b1; end
                   else begin r.res = x / y; r.res2 = x % y; end
            4'd5:  begin
                       t = sx + sy; p = 64'(x) + 64'(y);
                       r.res = p[31:0]; r.uof = p[32]; r.ovf = (t > SMAX) || (t < SMIN);
                   end
            4'd6:  begin
                       t = sx - sy;
                       r.res = x - y; r.uof = (x < y); r.ovf = (t > SMAX) || (t < SMIN);
                   end
            4'd7:  r.res = x & y;
            4'd8:  r.res = x | y;
            4'd9:  r.res = x ^ y;
            4'd10: r.res = ~(x | y);
            4'd11: r.res = W'(sx < sy);
            4'd12: r.res = W'(x < y);
`ifdef ALU_SIGNED_MULDIV_EN
            4'd13: begin t = sx * sy; r.res = t[31:0]; r.res2 = t[63:32]; end
            4'd14: if (y == 0) begin r.res = '1; r.res2 = x; r.dz = 1'b1; end
                   else begin
                       t = sx / sy; r.res = t[31:0];
                       t = sx % sy; r.res2 = t[31:0];
                   end
`endif
            default: ;
        endcase
        return r;
    endfunction

    int   edge_n = 0, rdy_from = 0, acc_from = 0, acc_edge = 0;
    bit   armed = 1'b0, exp_v = 1'b0, exp_rdy = 1'b1;
    rec_t q[$];
    rec_t exp_o = '{default: '0};

    // Model timeline: what the outputs must show after each rising edge
    always @(posedge clk) begin
        rec_t r;
        edge_n++;
        if (rst) begin
            q.delete();
            exp_o    = '{default: '0};
            exp_v    = 1'b0;
            armed    = 1'b1;
            rdy_from = edge_n;
            acc_from = edge_n + 1;
        end else begin
            if (bus.in_valid && edge_n >= acc_from) begin
                r = model(bus.S, bus.X, bus.Y);
                acc_edge = edge_n;
                if (is_long(bus.S)) begin
                    r.e      = edge_n + W;
                    rdy_from = edge_n + W + 1;
                    acc_from = edge_n + W + 2;
                end else begin
                    r.e = edge_n;
                end
                q.push_back(r);
            end
            exp_v = 1'b0;
            if (q.size() > 0 && q[0].e == edge_n) begin
                exp_o = q.pop_front();
                exp_v = 1'b1;
            end
        end
        exp_rdy = (edge_n >= rdy_from);
    end

    int   busy_cnt = 0;
    rec_t got[$];

    // Compare on the falling edge; outputs must match the model every cycle (held values included)
    always @(negedge clk) begin
        rec_t o;
        if (armed) begin
            o.res = bus.Result; o.res2 = bus.Result2;
            o.eq = bus.Equal; o.ovf = bus.overflow; o.uof = bus.UOF; o.dz = bus.div0;
            o.e = edge_n;
            chk("ready", 64'(bus.ready), 64'(exp_rdy));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
            chk("Result", 64'(o.res), 64'(exp_o.res));
            chk("Result2", 64'(o.res2), 64'(exp_o.res2));
            chk("flags_eq_ovf_uof_div0", 64'({o.eq, o.ovf, o.uof, o.dz}),
                64'({exp_o.eq, exp_o.ovf, exp_o.uof, exp_o.dz}));
            if (bus.out_valid === 1'b1) got.push_back(o);
            if (bus.ready === 1'b0) busy_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.in_valid = 1'b1; bus.S = s; bus.X = x; bus.Y = y;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_wait", 64'(bus.ready), 64'd1);
    endtask

    logic [W-1:0] xv [8] = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000,
                             32'hffffffff, 32'h12345678, 32'hfffffff9, 32'h100};
    logic [W-1:0] yv [8] = '{32'h0, 32'h3, 32'hffffffff, 32'h80000000,
                             32'h7, 32'h1f, 32'h21, 32'h2};

    initial begin
        #1000000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bus.in_valid = 1'b0; bus.S = '0; bus.X = '0; bus.Y = '0;
        step(2);
        rst = 1'b0;
        chk("reset_ready", 64'(bus.ready), 64'd1);
        chk("reset_result", 64'(bus.Result), 64'd0);

        // ADD overflow then SUB borrow, back to back
        got.delete();
        drive(4'd5, 32'h7fffffff, 32'h1);
        drive(4'd6, 32'h0, 32'h1);
        step(1);
        chk("addsub_count", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            chk("add_res", 64'(got[0].res), 64'h80000000);
            chk("add_ovf", 64'(got[0].ovf), 64'd1);
            chk("add_uof", 64'(got[0].uof), 64'd0);
            chk("sub_res", 64'(got[1].res), 64'hffffffff);
            chk("sub_uof", 64'(got[1].uof), 64'd1);
        end

        // Shifts on three consecutive cycles
        got.delete();
        drive(4'd0, 32'h80000000, 32'd3);
        drive(4'd1, 32'h80000000, 32'd3);
        drive(4'd2, 32'h80000000, 32'd3);
        step(1);
        chk("shift_count", 64'(got.size()), 64'd3);
        if (got.size() >= 3) begin
            chk("sll_res", 64'(got[0].res), 64'h00000000);
            chk("sra_res", 64'(got[1].res), 64'hf0000000);
            chk("srl_res", 64'(got[2].res), 64'h10000000);
            chk("shift_spacing", 64'(got[2].e - got[0].e), 64'd2);
        end

        // MULU all-ones: busy window and latency
        got.delete();
        busy_cnt = 0;
        drive(4'd3, 32'hffffffff, 32'hffffffff);
        wait_ready();
        step(2);
        chk("mulu_busy_cycles", 64'(busy_cnt), 64'd33);
        chk("mulu_count", 64'(got.size()), 64'd1);
        if (got.size() >= 1) begin
            chk("mulu_latency", 64'(got[0].e - acc_edge), 64'd32);
            chk("mulu_hi", 64'(got[0].res2), 64'hfffffffe);
            chk("mulu_lo", 64'(got[0].res), 64'h00000001);
        end

        // DIVU normal and divide by zero
        got.delete();
        drive(4'd4, 32'h100, 32'd7);
        wait_ready();
        drive(4'd4, 32'h5, 32'd0);
        wait_ready();
        step(1);
        chk("divu_count", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            chk("divu_q", 64'(got[0].res), 64'h00000024);
            chk("divu_r", 64'(got[0].res2), 64'h00000004);
            chk("divu0_q", 64'(got[1].res), 64'hffffffff);
            chk("divu0_r", 64'(got[1].res2), 64'h00000005);
            chk("divu0_flag", 64'(got[1].dz), 64'd1);
        end

`ifdef ALU_SIGNED_MULDIV_EN
        got.delete();
        drive(4'd14, 32'hfffffff9, 32'd2);
        wait_ready();
        drive(4'd13, 32'hfffffffd, 32'd5);
        wait_ready();
        drive(4'd14, 32'h80000000, 32'hffffffff);
        wait_ready();
        drive(4'd14, 32'hfffffff9, 32'd0);
        wait_ready();
        step(1);
        chk("signed_count", 64'(got.size()), 64'd4);
        if (got.size() >= 4) begin
            chk("divs_q", 64'(got[0].res), 64'hfffffffd);
            chk("divs_r", 64'(got[0].res2), 64'hffffffff);
            chk("muls_lo", 64'(got[1].res), 64'hfffffff1);
            chk("muls_hi", 64'(got[1].res2), 64'hffffffff);
            chk("divs_minneg_q", 64'(got[2].res), 64'h80000000);
            chk("divs_minneg_r", 64'(got[2].res2), 64'h0);
            chk("divs_minneg_ovf", 64'(got[2].ovf), 64'd0);
            chk("divs0_r", 64'(got[3].res2), 64'hfffffff9);
            chk("divs0_flag", 64'(got[3].dz), 64'd1);
        end
`else
        got.delete();
        drive(4'd13, 32'hfffffffd, 32'd5);
        step(1);
        chk("res13_count", 64'(got.size()), 64'd1);
        if (got.size() >= 1) begin
            chk("res13_res", 64'(got[0].res), 64'h0);
            chk("res13_res2", 64'(got[0].res2), 64'h0);
            chk("res13_latency", 64'(got[0].e - acc_edge), 64'd0);
        end
`endif

        // An op offered while busy is dropped
        got.delete();
        drive(4'd3, 32'd5, 32'd6);
        drive(4'd5, 32'd1, 32'd1);
        wait_ready();
        step(2);
        chk("busy_ignore_count", 64'(got.size()), 64'd1);
        if (got.size() >= 1) chk("busy_ignore_res", 64'(got[0].res), 64'h1e);

        // Reset in the middle of a DIVU
        got.delete();
        drive(4'd4, 32'h100, 32'd7);
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_result", 64'(bus.Result), 64'd0);
        chk("abort_result2", 64'(bus.Result2), 64'd0);
        drive(4'd5, 32'd2, 32'd3);
        step(40);
        chk("abort_count", 64'(got.size()), 64'd1);
        if (got.size() >= 1) chk("abort_add_res", 64'(got[0].res), 64'd5);

        // Sweep every op code over a small vector table
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 4; k++) begin
                wait_ready();
                drive(4'(op), xv[(op + k) % 8], yv[(op * 3 + k) % 8]);
            end
        end
        wait_ready();
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
